seg7_scan_reader: RTL
=====================

# seg7_scan_reader

Receive-side counterpart of the hex-to-seven-segment decoder. It samples a multiplexed, multi-digit seven-segment bus (segment lines a–g, dot, one-hot digit select), waits for each digit's pattern to be stable, and converts it back to a hex nibble. It outputs a complete multi-digit word with a one-cycle frame strobe. It is used as a loopback checker behind display drivers and as a front end for capturing external display buses.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits; value width is 4*DIGITS.
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured; legal range 2–255.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- a, b, c, d, e, f, g  input  1 each  segment lines, active-high; pattern order {a,b,c,d,e,f,g}, a = MSB.
- dot  input  1  decimal-point line, active-high.
- digit_sel  input  DIGITS  digit enable, active-high, one-hot; bit 0 is the least significant digit.
- value  output  4*DIGITS  last complete frame; digit k occupies bits [4k+3:4k].
- invalid  output  DIGITS  per-digit flag; set when the captured pattern is not one of the 16 legal codes.
- dots  output  DIGITS  per-digit captured dot (see Configuration).
- frame_valid  output  1  one-cycle pulse when value, invalid and dots update.

## Operation
- Sample register: each cycle, register {pattern, dot, digit_sel} and compare it with the previous cycle's sample.
  - When `SEG7_DOT_CAPTURE_EN` is undefined, dot is excluded from the compare.
- Stability counter (8 bits):
  - Cleared to 1 when the sample differs from the previous sample, or when digit_sel is not one-hot (zero or multiple bits set).
  - Otherwise increments, saturating at STABLE_CYCLES.
- FSM states:
  - SETTLE → CAPTURE when the counter reaches STABLE_CYCLES and digit_sel is one-hot.
  - CAPTURE → HOLD after exactly one cycle.
  - HOLD → SETTLE on any sample change or non-one-hot select.
  - Result: each dwell produces exactly one capture, however long it lasts.
- Capture (in the CAPTURE cycle):
  - Decode the pattern with the exact inverse of the encoder table:
    - 0–3: 1111110→0, 0110000→1, 1101101→2, 1111001→3
    - 4–7: 0110011→4, 1011011→5, 1011111→6, 1110000→7
    - 8–B: 1111111→8, 1111011→9, 1110111→A, 0011111→B
    - C–F: 1001110→C, 0111101→D, 1001111→E, 1000111→F
  - Any other pattern decodes to nibble 0 and sets that digit's invalid bit in the shadow frame.
  - Write the nibble, invalid bit and dot into a shadow frame slot selected by digit_sel, and set the matching bit of captured_mask.
- Frame completion:
  - When captured_mask is all ones, copy the shadow frame to value/invalid/dots, pulse frame_valid and clear captured_mask.
  - Recapturing a digit before the frame completes overwrites its shadow slot; the mask bit stays set.
- Digit order does not matter; a frame completes when every digit has been captured at least once.

## Timing
- Reset values:
  - value, invalid, dots, frame_valid = 0.
  - FSM in SETTLE, counter = 0, captured_mask = 0, shadow frame = 0, sample register = 0.
- Capture latency: a digit presented constantly from cycle t is captured at the edge ending cycle t+STABLE_CYCLES (one cycle of sample registration plus STABLE_CYCLES-1 matching compares).
- frame_valid asserts the cycle after the final digit's capture edge. Outputs change only on that edge and hold until the next frame.
- Simultaneous events: a capture that completes the mask and the frame copy happen together. The shadow write lands in the copied frame, not the next one.
- Reset mid-frame: the partial frame is discarded and outputs return to 0 on the next edge.
- Glitch shorter than STABLE_CYCLES: no capture; the FSM stays in or returns to SETTLE.

## Configuration
- `SEG7_DOT_CAPTURE_EN` defined:
  - dot participates in the stability compare.
  - dot is captured per digit and published on dots.
- `SEG7_DOT_CAPTURE_EN` undefined:
  - dot is ignored.
  - dots is tied to 0.
  - Dot-capture registers are not synthesized.

## Test plan
- Reset, then present digits 0..3 with patterns for 1, 2, 3, 4, each held 8 cycles (STABLE_CYCLES=4) → one frame_valid pulse; value=16'h4321, invalid=0.
- Hold digit 0 = 1110111 for 40 cycles, then digits 1–3 = 0011111, 1001110, 0111101 → exactly one capture per dwell; value=16'hDCBA.
- Present pattern 0000001 on digit 2, legal codes on the others → invalid=4'b0100, nibble 2 = 0, frame_valid pulses once.
- Toggle segment g every 2 cycles on digit 0, and drive digit_sel=4'b0011 for 10 cycles → no capture, no frame_valid; a following clean frame for 8,8,8,8 gives value=16'h8888.
- Assert rst after 3 of 4 digits are captured, then present a full frame for F,E,D,C on digits 3..0 → outputs 0 during reset; exactly one frame_valid afterwards with value=16'hFEDC.
- With `SEG7_DOT_CAPTURE_EN` set, dot=1 on digit 1 only → dots=4'b0010. Without the macro, the same stimulus gives dots=0.

Source files
------------

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers a multi-digit hex word from a multiplexed seven-segment bus.
// Optional feature macro SEG7_DOT_CAPTURE_EN: dot joins the stability compare and is captured per digit.
module seg7_scan_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a,
  input  logic                  b,
  input  logic                  c,
  input  logic                  d,
  input  logic                  e,
  input  logic                  f,
  input  logic                  g,
  input  logic                  dot,
  input  logic [DIGITS-1:0]     digit_sel,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     invalid,
  output logic [DIGITS-1:0]     dots,
  output logic                  frame_valid
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
`ifdef SEG7_DOT_CAPTURE_EN
  localparam int SAMPLE_W = 8 + DIGITS;
`else
  localparam int SAMPLE_W = 7 + DIGITS;
`endif

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  // Inverse of the encoder table; bit 4 flags an illegal pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    case (pat)
      7'b1111110: seg_decode = 5'h00;
      7'b0110000: seg_decode = 5'h01;
      7'b1101101: seg_decode = 5'h02;
      7'b1111001: seg_decode = 5'h03;
      7'b0110011: seg_decode = 5'h04;
      7'b1011011: seg_decode = 5'h05;
      7'b1011111: seg_decode = 5'h06;
      7'b1110000: seg_decode = 5'h07;
      7'b1111111: seg_decode = 5'h08;
      7'b1111011: seg_decode = 5'h09;
      7'b1110111: seg_decode = 5'h0A;
      7'b0011111: seg_decode = 5'h0B;
      7'b1001110: seg_decode = 5'h0C;
      7'b0111101: seg_decode = 5'h0D;
      7'b1001111: seg_decode = 5'h0E;
      7'b1000111: seg_decode = 5'h0F;
      default:    seg_decode = 5'h10;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [DIGITS-1:0] x);
    return (x != {DIGITS{1'b0}}) && ((x & (x - DIGITS'(1))) == {DIGITS{1'b0}});
  endfunction

  logic [SAMPLE_W-1:0] sample_d, sample_q;
  logic [DIGITS-1:0]   sel_s;
  logic [6:0]          pat_s;
  logic                sel_ok_s;
  logic                capture_s;
  logic                frame_done_s;
  logic [4:0]          dec_s;
  logic [7:0]          cnt_d, cnt_q;
  state_t              state_d, state_q;
  logic [4*DIGITS-1:0] shadow_val_d, shadow_val_q, value_d, value_q;
  logic [DIGITS-1:0]   shadow_inv_d, shadow_inv_q, invalid_d, invalid_q;
  logic [DIGITS-1:0]   mask_d, mask_q;
  logic                frame_valid_d, frame_valid_q;

`ifdef SEG7_DOT_CAPTURE_EN
  assign sample_d = {a, b, c, d, e, f, g, dot, digit_sel};
`else
  logic dot_unused;
  assign dot_unused = dot;
  assign sample_d   = {a, b, c, d, e, f, g, digit_sel};
`endif

  assign sel_s     = sample_q[DIGITS-1:0];
  assign pat_s     = sample_q[SAMPLE_W-1 -: 7];
  assign sel_ok_s  = is_onehot(digit_sel);
  assign capture_s = (state_q == ST_CAPTURE);
  assign dec_s     = seg_decode(pat_s);

  // Stability counter and dwell FSM; HOLD also exits if a new dwell began during CAPTURE.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if ((sample_d != sample_q) || !sel_ok_s) begin
      cnt_d = 8'd1;
    end else if (cnt_q >= STABLE_MAX) begin
      cnt_d = STABLE_MAX;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    case (state_q)
      ST_SETTLE:  state_d = (sel_ok_s && (cnt_d == STABLE_MAX)) ? ST_CAPTURE : ST_SETTLE;
      ST_CAPTURE: state_d = ST_HOLD;
      ST_HOLD:    state_d = ((cnt_d != STABLE_MAX) || (cnt_q != STABLE_MAX)) ? ST_SETTLE : ST_HOLD;
      default:    state_d = ST_SETTLE;
    endcase
  end

  // Shadow-frame write and frame publication; a completing capture lands in the published frame.
  always_comb begin
    shadow_val_d  = shadow_val_q;
    shadow_inv_d  = shadow_inv_q;
    mask_d        = mask_q;
    value_d       = value_q;
    invalid_d     = invalid_q;
    frame_valid_d = 1'b0;
    frame_done_s  = 1'b0;
    if (capture_s) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (sel_s[k]) begin
          shadow_val_d[4*k +: 4] = dec_s[3:0];
          shadow_inv_d[k]        = dec_s[4];
        end else begin
          shadow_inv_d[k]        = shadow_inv_q[k];
        end
      end
      mask_d = mask_q | sel_s;
    end else begin
      mask_d = mask_q;
    end
    if (mask_d == {DIGITS{1'b1}}) begin
      frame_done_s  = 1'b1;
      value_d       = shadow_val_d;
      invalid_d     = shadow_inv_d;
      frame_valid_d = 1'b1;
      mask_d        = {DIGITS{1'b0}};
    end else begin
      frame_done_s  = 1'b0;
    end
  end

  // State, sample and frame registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q      <= {SAMPLE_W{1'b0}};
      cnt_q         <= 8'd0;
      state_q       <= ST_SETTLE;
      shadow_val_q  <= {(4*DIGITS){1'b0}};
      shadow_inv_q  <= {DIGITS{1'b0}};
      mask_q        <= {DIGITS{1'b0}};
      value_q       <= {(4*DIGITS){1'b0}};
      invalid_q     <= {DIGITS{1'b0}};
      frame_valid_q <= 1'b0;
    end else begin
      sample_q      <= sample_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      shadow_val_q  <= shadow_val_d;
      shadow_inv_q  <= shadow_inv_d;
      mask_q        <= mask_d;
      value_q       <= value_d;
      invalid_q     <= invalid_d;
      frame_valid_q <= frame_valid_d;
    end
  end

`ifdef SEG7_DOT_CAPTURE_EN
  logic [DIGITS-1:0] dot_shadow_d, dot_shadow_q, dots_d, dots_q;

  // Per-digit dot capture, published alongside the value frame.
  always_comb begin
    dot_shadow_d = dot_shadow_q;
    dots_d       = dots_q;
    if (capture_s) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (sel_s[k]) begin
          dot_shadow_d[k] = sample_q[DIGITS];
        end else begin
          dot_shadow_d[k] = dot_shadow_q[k];
        end
      end
    end else begin
      dot_shadow_d = dot_shadow_q;
    end
    if (frame_done_s) begin
      dots_d = dot_shadow_d;
    end else begin
      dots_d = dots_q;
    end
  end

  // Dot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dot_shadow_q <= {DIGITS{1'b0}};
      dots_q       <= {DIGITS{1'b0}};
    end else begin
      dot_shadow_q <= dot_shadow_d;
      dots_q       <= dots_d;
    end
  end

  assign dots = dots_q;
`else
  assign dots = {DIGITS{1'b0}};
`endif

  assign value       = value_q;
  assign invalid     = invalid_q;
  assign frame_valid = frame_valid_q;

endmodule
